saturn_mem_arbiter: RTL and testbench

//  Shares the single external memory port (ROM / RAM-L / RAM-H) between two requesters:

---
 rtl/saturn_pkg.sv | 44 ++++
 rtl/mem_arb_port_mux.sv | 29 ++
 rtl/saturn_mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_saturn_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/saturn_pkg.sv
// Shared types and constants for the Saturn external memory arbiter.
package saturn_pkg;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ROM  = 2'd0,
    RAML = 2'd1,
    RAMH = 2'd2,
    NONE = 2'd3
  } mem_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } arb_state_t;

  localparam logic [DATA_W-1:0] UNMAPPED_DATA = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    mem_sel_t          sel;
    logic [BE_W-1:0]   we_n;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Chip selects as {RAMH, RAML, ROM}, active low.
  function automatic logic [2:0] sel_to_cs_n(input mem_sel_t sel);
    logic [2:0] cs_n;
    cs_n = 3'b111;
    case (sel)
      ROM:     cs_n = 3'b110;
      RAML:    cs_n = 3'b101;
      RAMH:    cs_n = 3'b011;
      default: cs_n = 3'b111;
    endcase
    return cs_n;
  endfunction

endpackage

// File: rtl/mem_arb_port_mux.sv
// Two-port request selector: picks the winning requester and forwards its payload.
module mem_arb_port_mux
  import saturn_pkg::*;
#(
  parameter bit A_PRIORITY = 1'b0
) (
  input  logic     i_a_req,
  input  logic     i_b_req,
  input  logic     i_last_b,
  input  mem_req_t i_a,
  input  mem_req_t i_b,
  output logic     o_gnt_c,
  output logic     o_gnt_b_c,
  output mem_req_t o_req_c
);

  // On a tie, round-robin hands the port to whoever did not go last.
  always_comb begin
    o_gnt_c   = i_a_req | i_b_req;
    o_gnt_b_c = 1'b0;
    if (i_b_req && !i_a_req) begin
      o_gnt_b_c = 1'b1;
    end else if (i_a_req && i_b_req) begin
      o_gnt_b_c = A_PRIORITY ? 1'b0 : ~i_last_b;
    end
    o_req_c = o_gnt_b_c ? i_b : i_a;
  end

endmodule

// File: rtl/saturn_mem_arbiter.sv
// Arbitrates the external ROM/RAM-L/RAM-H port between the CPU (A) and SCU DMA (B)
// and sequences chip select, strobes, wait handling and completion.
module saturn_mem_arbiter
  import saturn_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter bit          A_PRIORITY  = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce_r,
  input  logic              i_a_req,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [1:0]        i_a_sel,
  input  logic [BE_W-1:0]   i_a_we_n,
  input  logic [DATA_W-1:0] i_a_do,
  output logic [DATA_W-1:0] o_a_di,
  output logic              o_a_ack,
  input  logic              i_b_req,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [1:0]        i_b_sel,
  input  logic [BE_W-1:0]   i_b_we_n,
  input  logic [DATA_W-1:0] i_b_do,
  output logic [DATA_W-1:0] o_b_di,
  output logic              o_b_ack,
  output logic [ADDR_W-1:0] o_mem_a,
  output logic [DATA_W-1:0] o_mem_do,
  input  logic [DATA_W-1:0] i_mem_di,
  output logic [BE_W-1:0]   o_mem_dqm_n,
  output logic              o_mem_rd_n,
  output logic              o_rom_cs_n,
  output logic              o_raml_cs_n,
  output logic              o_ramh_cs_n,
  input  logic              i_mem_wait_n,
  output logic              o_grant_b,
  output logic              o_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);

  arb_state_t        r_state;
  mem_req_t          r_hold;
  logic              r_last_b;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_err;
  logic              r_a_ack;
  logic              r_b_ack;
  logic [DATA_W-1:0] r_a_di;
  logic [DATA_W-1:0] r_b_di;
  logic [2:0]        r_cs_n;
  logic              r_rd_n;
  logic [BE_W-1:0]   r_dqm_n;

  arb_state_t        w_state_nxt;
  mem_req_t          w_hold_nxt;
  logic              w_last_b_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_err_nxt;
  logic              w_a_ack_nxt;
  logic              w_b_ack_nxt;
  logic [DATA_W-1:0] w_a_di_nxt;
  logic [DATA_W-1:0] w_b_di_nxt;
  logic [2:0]        w_cs_n_nxt;
  logic              w_rd_n_nxt;
  logic [BE_W-1:0]   w_dqm_n_nxt;
  logic              w_done;
  logic [DATA_W-1:0] w_rdata;
  logic              w_drive;
  mem_req_t          w_drv_req;

  mem_req_t          w_a_req;
  mem_req_t          w_b_req;
  logic              w_gnt;
  logic              w_gnt_b;
  mem_req_t          w_mux_req;

  assign w_a_req = {i_a_addr, i_a_sel, i_a_we_n, i_a_do};
  assign w_b_req = {i_b_addr, i_b_sel, i_b_we_n, i_b_do};

  mem_arb_port_mux #(
    .A_PRIORITY(A_PRIORITY)
  ) u_port_mux (
    .i_a_req  (i_a_req),
    .i_b_req  (i_b_req),
    .i_last_b (r_last_b),
    .i_a      (w_a_req),
    .i_b      (w_b_req),
    .o_gnt_c  (w_gnt),
    .o_gnt_b_c(w_gnt_b),
    .o_req_c  (w_mux_req)
  );

  // Next-state, completion and strobe decode; strobes are registered from the next state.
  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold;
    w_last_b_nxt = r_last_b;
    w_cnt_nxt    = r_wait_cnt;
    w_err_nxt    = r_err;
    w_a_ack_nxt  = 1'b0;
    w_b_ack_nxt  = 1'b0;
    w_a_di_nxt   = r_a_di;
    w_b_di_nxt   = r_b_di;
    w_cs_n_nxt   = 3'b111;
    w_rd_n_nxt   = 1'b1;
    w_dqm_n_nxt  = {BE_W{1'b1}};
    w_done       = 1'b0;
    w_rdata      = '0;
    w_drive      = 1'b0;
    w_drv_req    = r_hold;

    case (r_state)
      ST_IDLE: begin
        if (w_gnt) begin
          w_hold_nxt   = w_mux_req;
          w_last_b_nxt = w_gnt_b;
          w_cnt_nxt    = '0;
          w_drive      = 1'b1;
          w_drv_req    = w_mux_req;
          w_state_nxt  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_hold.sel == NONE) begin
          w_done  = 1'b1;
          w_rdata = UNMAPPED_DATA;
        end else if (i_mem_wait_n) begin
          w_done  = 1'b1;
          w_rdata = (r_hold.we_n == {BE_W{1'b1}}) ? i_mem_di : '0;
        end else if ((r_wait_cnt + CNT_W'(1)) == TIMEOUT_LIM) begin
          w_done    = 1'b1;
          w_rdata   = UNMAPPED_DATA;
          w_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_wait_cnt + CNT_W'(1);
          w_drive   = 1'b1;
        end
        if (w_done) begin
          w_state_nxt = ST_RECOVER;
        end
      end
      ST_RECOVER: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase

    if (w_drive && (w_drv_req.sel != NONE)) begin
      w_cs_n_nxt = sel_to_cs_n(w_drv_req.sel);
      if (w_drv_req.we_n == {BE_W{1'b1}}) begin
        w_rd_n_nxt = 1'b0;
      end else begin
        w_dqm_n_nxt = w_drv_req.we_n;
      end
    end

    if (w_done) begin
      if (r_last_b) begin
        w_b_ack_nxt = 1'b1;
        w_b_di_nxt  = w_rdata;
      end else begin
        w_a_ack_nxt = 1'b1;
        w_a_di_nxt  = w_rdata;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_hold     <= '0;
      r_last_b   <= 1'b0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_a_di     <= '0;
      r_b_di     <= '0;
      r_cs_n     <= 3'b111;
      r_rd_n     <= 1'b1;
      r_dqm_n    <= {BE_W{1'b1}};
    end else if (i_ce_r) begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_last_b   <= w_last_b_nxt;
      r_wait_cnt <= w_cnt_nxt;
      r_err      <= w_err_nxt;
      r_a_ack    <= w_a_ack_nxt;
      r_b_ack    <= w_b_ack_nxt;
      r_a_di     <= w_a_di_nxt;
      r_b_di     <= w_b_di_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_rd_n     <= w_rd_n_nxt;
      r_dqm_n    <= w_dqm_n_nxt;
    end
  end

  assign o_a_di      = r_a_di;
  assign o_a_ack     = r_a_ack;
  assign o_b_di      = r_b_di;
  assign o_b_ack     = r_b_ack;
  assign o_mem_a     = r_hold.addr;
  assign o_mem_do    = r_hold.wdata;
  assign o_mem_dqm_n = r_dqm_n;
  assign o_mem_rd_n  = r_rd_n;
  assign o_rom_cs_n  = r_cs_n[0];
  assign o_raml_cs_n = r_cs_n[1];
  assign o_ramh_cs_n = r_cs_n[2];
  assign o_grant_b   = r_last_b;
  assign o_err       = r_err;

endmodule

// File: tb/tb_saturn_mem_arbiter.sv
// Directed bench for saturn_mem_arbiter (TIMEOUT_CYC=16, round-robin ties).
module tb_saturn_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ce_r;
  logic        a_req, b_req;
  logic [24:0] a_addr, b_addr;
  logic [1:0]  a_sel, b_sel;
  logic [3:0]  a_we_n, b_we_n;
  logic [31:0] a_do, b_do;
  logic [31:0] a_di, b_di;
  logic        a_ack, b_ack;
  logic [24:0] mem_a;
  logic [31:0] mem_do;
  logic [31:0] mem_di;
  logic [3:0]  mem_dqm_n;
  logic        mem_rd_n, rom_cs_n, raml_cs_n, ramh_cs_n;
  logic        mem_wait_n;
  logic        grant_b;
  logic        err;

  int n_checks = 0;
  int n_err    = 0;

  saturn_mem_arbiter #(
    .TIMEOUT_CYC(16),
    .A_PRIORITY (1'b0)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ce_r      (ce_r),
    .i_a_req     (a_req),
    .i_a_addr    (a_addr),
    .i_a_sel     (a_sel),
    .i_a_we_n    (a_we_n),
    .i_a_do      (a_do),
    .o_a_di      (a_di),
    .o_a_ack     (a_ack),
    .i_b_req     (b_req),
    .i_b_addr    (b_addr),
    .i_b_sel     (b_sel),
    .i_b_we_n    (b_we_n),
    .i_b_do      (b_do),
    .o_b_di      (b_di),
    .o_b_ack     (b_ack),
    .o_mem_a     (mem_a),
    .o_mem_do    (mem_do),
    .i_mem_di    (mem_di),
    .o_mem_dqm_n (mem_dqm_n),
    .o_mem_rd_n  (mem_rd_n),
    .o_rom_cs_n  (rom_cs_n),
    .o_raml_cs_n (raml_cs_n),
    .o_ramh_cs_n (ramh_cs_n),
    .i_mem_wait_n(mem_wait_n),
    .o_grant_b   (grant_b),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Pin snapshot {ROM_CS_N, RAML_CS_N, RAMH_CS_N, RD_N, DQM_N[3:0]}.
  function automatic logic [31:0] pins();
    return 32'({rom_cs_n, raml_cs_n, ramh_cs_n, mem_rd_n, mem_dqm_n});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] P_IDLE    = 32'h0000_00FF;
  localparam logic [31:0] P_RAML_RD = 32'h0000_00AF;
  localparam logic [31:0] P_RAMH_RD = 32'h0000_00CF;
  localparam logic [31:0] P_ROM_RD  = 32'h0000_006F;
  localparam logic [31:0] P_RAMH_WR = 32'h0000_00DC;

  int n;

  initial begin
    rst = 1'b1; ce_r = 1'b1;
    a_req = 1'b0; a_addr = '0; a_sel = 2'd0; a_we_n = 4'hF; a_do = '0;
    b_req = 1'b0; b_addr = '0; b_sel = 2'd0; b_we_n = 4'hF; b_do = '0;
    mem_di = '0; mem_wait_n = 1'b1;
    #3;
    chk("rst_pins", pins(), P_IDLE);
    chk("rst_mem_a", 32'(mem_a), 32'h0);
    chk("rst_acks", 32'({a_ack, b_ack, grant_b, err}), 32'h0);
    chk("rst_di", a_di | b_di, 32'h0);
    #9 rst = 1'b0;

    // 1: A reads RAM-L, no wait
    a_req = 1'b1; a_sel = 2'd1; a_addr = 25'h020_0000; a_we_n = 4'hF;
    mem_di = 32'h1234_5678;
    step();
    chk("t1_strobe", pins(), P_RAML_RD);
    chk("t1_addr", 32'(mem_a), 32'h0020_0000);
    chk("t1_noack", 32'(a_ack), 32'h0);
    step();
    chk("t1_ack", 32'(a_ack), 32'h1);
    chk("t1_di", a_di, 32'h1234_5678);
    chk("t1_release", pins(), P_IDLE);
    a_req = 1'b0;
    step();
    chk("t1_ack_pulse", 32'(a_ack), 32'h0);
    chk("t1_di_hold", a_di, 32'h1234_5678);

    // 2: tie after an A access -> B first, then A
    a_req = 1'b1; a_sel = 2'd0; a_addr = 25'h100; a_we_n = 4'hF;
    b_req = 1'b1; b_sel = 2'd2; b_addr = 25'h1234; b_we_n = 4'hF;
    mem_di = 32'hB0B0_0001;
    step();
    chk("t2_grant_b", 32'(grant_b), 32'h1);
    chk("t2_b_strobe", pins(), P_RAMH_RD);
    chk("t2_b_addr", 32'(mem_a), 32'h0000_1234);
    step();
    chk("t2_b_ack", 32'({a_ack, b_ack}), 32'h1);
    chk("t2_b_di", b_di, 32'hB0B0_0001);
    chk("t2_a_di_hold", a_di, 32'h1234_5678);
    b_req = 1'b0;
    step();
    chk("t2_recover", pins(), P_IDLE);
    chk("t2_grant_b_hold", 32'(grant_b), 32'h1);
    mem_di = 32'hA0A0_0002;
    step();
    chk("t2_grant_a", 32'(grant_b), 32'h0);
    chk("t2_a_strobe", pins(), P_ROM_RD);
    chk("t2_a_addr", 32'(mem_a), 32'h0000_0100);
    step();
    chk("t2_a_ack", 32'({a_ack, b_ack}), 32'h2);
    chk("t2_a_di", a_di, 32'hA0A0_0002);
    a_req = 1'b0;
    step();

    // 3: B write to RAM-H with 5 wait ticks
    b_req = 1'b1; b_sel = 2'd2; b_addr = 25'h40; b_we_n = 4'b1100; b_do = 32'hCAFE_BABE;
    mem_wait_n = 1'b0;
    step();
    chk("t3_strobe", pins(), P_RAMH_WR);
    chk("t3_mem_do", mem_do, 32'hCAFE_BABE);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t3_wait%0d", i), 32'({b_ack, 7'h0, pins()[7:0]}), {24'h0, P_RAMH_WR[7:0]});
    end
    mem_wait_n = 1'b1;
    step();
    chk("t3_ack", 32'(b_ack), 32'h1);
    chk("t3_di_write", b_di, 32'h0);
    chk("t3_release", pins(), P_IDLE);
    chk("t3_err", 32'(err), 32'h0);
    b_req = 1'b0;
    step();

    // 4: wait stuck low -> timeout after 16 wait ticks
    a_req = 1'b1; a_sel = 2'd0; a_addr = 25'h8; a_we_n = 4'hF;
    mem_wait_n = 1'b0;
    step();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (a_ack) break;
    end
    chk("t4_ticks", 32'(n), 32'd16);
    chk("t4_di", a_di, 32'hFFFF_FFFF);
    chk("t4_err", 32'(err), 32'h1);
    chk("t4_release", pins(), P_IDLE);
    a_req = 1'b0;
    step();
    step();
    chk("t4_err_sticky", 32'(err), 32'h1);

    // 5: unmapped select
    a_req = 1'b1; a_sel = 2'd3; a_addr = 25'h1FF_FFFF;
    a_di_clear: begin end
    step();
    chk("t5_no_strobe", pins(), P_IDLE);
    chk("t5_noack", 32'(a_ack), 32'h0);
    step();
    chk("t5_ack", 32'(a_ack), 32'h1);
    chk("t5_di", a_di, 32'hFFFF_FFFF);
    chk("t5_pins", pins(), P_IDLE);
    a_req = 1'b0;
    step();

    // 6: reset during an access
    b_req = 1'b1; b_sel = 2'd1; b_addr = 25'h77; b_we_n = 4'hF;
    step();
    chk("t6_strobe", pins(), P_RAML_RD);
    rst = 1'b1;
    #1;
    chk("t6_rst_pins", pins(), P_IDLE);
    chk("t6_rst_flags", 32'({a_ack, b_ack, grant_b, err}), 32'h0);
    #2 rst = 1'b0;
    mem_wait_n = 1'b1; mem_di = 32'h5A5A_0001;
    step();
    chk("t6_regrant", 32'({grant_b, b_ack}), 32'h2);
    chk("t6_regrant_pins", pins(), P_RAML_RD);
    step();
    chk("t6_ack", 32'(b_ack), 32'h1);
    chk("t6_di", b_di, 32'h5A5A_0001);
    b_req = 1'b0;
    step();

    // Clock enable gating
    a_req = 1'b1; a_sel = 2'd0; a_addr = 25'h3; a_we_n = 4'hF;
    mem_wait_n = 1'b0; mem_di = 32'h0C0C_0003;
    ce_r = 1'b0;
    step();
    step();
    chk("ce_idle_frozen", pins(), P_IDLE);
    ce_r = 1'b1;
    step();
    chk("ce_grant", pins(), P_ROM_RD);
    ce_r = 1'b0; mem_wait_n = 1'b1;
    step();
    step();
    chk("ce_access_frozen", 32'({a_ack, 7'h0, pins()[7:0]}), {24'h0, P_ROM_RD[7:0]});
    ce_r = 1'b1;
    step();
    chk("ce_ack", 32'(a_ack), 32'h1);
    chk("ce_di", a_di, 32'h0C0C_0003);
    ce_r = 1'b0; a_req = 1'b0;
    step();
    chk("ce_ack_held", 32'(a_ack), 32'h1);
    ce_r = 1'b1;
    step();
    chk("ce_ack_done", 32'(a_ack), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
